// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes and default latencies shared by the multiply/divide unit and its decoder
package mdu_pkg;
    typedef logic [3:0] op_t;
    localparam op_t MULT  = 4'd0;
    localparam op_t MULTU = 4'd1;
    localparam op_t DIV   = 4'd2;
    localparam op_t DIVU  = 4'd3;
    localparam op_t MTHI  = 4'd4;
    localparam op_t MTLO  = 4'd5;
    localparam op_t MADD  = 4'd6;
    localparam op_t MSUB  = 4'd7;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;
endpackage

// File: rtl/mdu.sv
// mdu: multi-cycle HI/LO multiply/divide unit; defining MDU_MADD_EN adds MADD/MSUB
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
    logic [CW-1:0] cnt;
    op_t op_q;
    logic [31:0] a_q, b_q, a_mag, b_mag, uq, ur, q, r;
    logic [63:0] acc, ps, pu, res;
    logic is_md, is_div;
    assign busy = cnt != '0;
    assign acc = {hi, lo};
    assign ps = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign pu = {32'b0, a_q} * {32'b0, b_q};
    // signed divide through magnitudes so 0x80000000 / -1 yields 0x80000000 without overflow
    assign a_mag = a_q[31] ? -a_q : a_q;
    assign b_mag = b_q[31] ? -b_q : b_q;
    assign uq = a_mag / b_mag;
    assign ur = a_mag % b_mag;
    assign q = (a_q[31] ^ b_q[31]) ? -uq : uq;
    assign r = a_q[31] ? -ur : ur;
    assign is_div = op == DIV || op == DIVU;
`ifdef MDU_MADD_EN
    assign is_md = op <= MSUB && op != MTHI && op != MTLO;
`else
    assign is_md = op <= DIVU;
`endif
    always_comb begin
        res = acc;
        case (op_q)
            MULT:  res = ps;
            MULTU: res = pu;
            DIV:   res = b_q == '0 ? acc : {r, q};
            DIVU:  res = b_q == '0 ? acc : {a_q % b_q, a_q / b_q};
`ifdef MDU_MADD_EN
            MADD:  res = acc + ps;
            MSUB:  res = acc - ps;
`endif
            default: res = acc;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            op_q <= MULT;
            a_q <= '0;
            b_q <= '0;
            hi <= '0;
            lo <= '0;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) {hi, lo} <= res;
        end else if (start) begin
            if (is_md) begin
                op_q <= op;
                a_q <= a;
                b_q <= b;
                cnt <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end else if (op == MTHI) begin
                hi <= a;
            end else if (op == MTLO) begin
                lo <= a;
            end
        end
    end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized self-checking bench for mdu against an arithmetic reference model
module tb_mdu;
    import mdu_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1, start = 1'b0, busy;
    op_t op = MULT;
    logic [31:0] a = '0, b = '0, hi, lo;
    logic [31:0] m_hi = '0, m_lo = '0;
    int total = 0, bad = 0;

    mdu dut (.clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
             .busy(busy), .hi(hi), .lo(lo));

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int lat(input op_t o);
        if (o == MULT || o == MULTU) return 5;
        if (o == DIV || o == DIVU) return 10;
`ifdef MDU_MADD_EN
        if (o == MADD || o == MSUB) return 5;
`endif
        return 0;
    endfunction

    function automatic void model(input op_t o, input logic [31:0] x, input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint unsigned ux = {32'b0, x};
        longint unsigned uy = {32'b0, y};
        longint p = sx * sy;
        case (o)
            MULT:  {m_hi, m_lo} = p;
            MULTU: {m_hi, m_lo} = ux * uy;
            DIV:   if (y != 0) begin m_lo = 32'(sx / sy); m_hi = 32'(sx % sy); end
            DIVU:  if (y != 0) begin m_lo = x / y; m_hi = x % y; end
            MTHI:  m_hi = x;
            MTLO:  m_lo = x;
`ifdef MDU_MADD_EN
            MADD:  {m_hi, m_lo} = {m_hi, m_lo} + p;
            MSUB:  {m_hi, m_lo} = {m_hi, m_lo} - p;
`endif
            default: ;
        endcase
    endfunction

    // issue one command, count busy cycles (bounded), note whether hi/lo moved while busy
    task automatic run(input op_t o, input logic [31:0] x, input logic [31:0] y, input bit noise,
                       output int n, output bit stable);
        logic [31:0] h0, l0;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        h0 = hi; l0 = lo; n = 0; stable = 1'b1;
        while (busy && n < 100) begin
            n++;
            if (hi !== h0 || lo !== l0) stable = 1'b0;
            if (noise) begin
                start = $urandom_range(0, 1) == 1;
                op = op_t'($urandom_range(0, 15));
                a = $urandom; b = $urandom;
            end
            @(negedge clk);
        end
        start = 1'b0;
        model(o, x, y);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset hi: got %h want 0", hi); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset lo: got %h want 0", lo); end
    endtask

    task automatic test_mult();
        int n; bit st;
        run(MULT, 32'hFFFFFFFD, 32'd5, 1'b0, n, st);
        total++; if (n != 5) begin bad++; $display("FAIL mult busy cycles: got %0d want 5", n); end
        total++; if (!st) begin bad++; $display("FAIL mult hi/lo moved while busy: got 0 want 1"); end
        total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult hi: got %h want ffffffff", hi); end
        total++; if (lo !== 32'hFFFFFFF1) begin bad++; $display("FAIL mult lo: got %h want fffffff1", lo); end
    endtask

    task automatic test_multu_div();
        int n; bit st;
        run(MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, n, st);
        total++; if (hi !== 32'h1 || lo !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu: got %h_%h want 00000001_fffffffe", hi, lo); end
        run(DIV, 32'hFFFFFFF9, 32'd2, 1'b0, n, st);
        total++; if (n != 10) begin bad++; $display("FAIL div busy cycles: got %0d want 10", n); end
        total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div: got %h_%h want ffffffff_fffffffd", hi, lo); end
    endtask

    task automatic test_mthi_div0();
        int n; bit st;
        run(MTLO, 32'h0, 32'h0, 1'b0, n, st);
        run(MTHI, 32'h12345678, 32'h0, 1'b0, n, st);
        total++; if (n != 0 || hi !== 32'h12345678) begin bad++; $display("FAIL mthi: got busy=%0d hi=%h want 0 12345678", n, hi); end
        run(DIVU, 32'd7, 32'd0, 1'b0, n, st);
        total++; if (n != 10) begin bad++; $display("FAIL div0 busy cycles: got %0d want 10", n); end
        total++; if (hi !== 32'h12345678 || lo !== 32'h0) begin bad++; $display("FAIL div0: got %h_%h want 12345678_00000000", hi, lo); end
        run(DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, n, st);
        total++; if (hi !== 32'h0 || lo !== 32'h80000000) begin bad++; $display("FAIL div overflow: got %h_%h want 00000000_80000000", hi, lo); end
    endtask

    task automatic test_ignore_start();
        @(negedge clk); start = 1'b1; op = MULT; a = 32'd3; b = 32'd4;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; op = DIVU; a = 32'd9; b = 32'd2;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ignore cycle5 busy: got %b want 1", busy); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || lo !== 32'd12 || hi !== 32'd0) begin bad++; $display("FAIL ignore cycle6: got busy=%b %h_%h want 0 00000000_0000000c", busy, hi, lo); end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore relatch busy: got %b want 0", busy); end
        model(MULT, 32'd3, 32'd4);
    endtask

    task automatic test_reset_abort();
        int n; bit st; bit quiet = 1'b1;
        run(MTHI, 32'hAAAA5555, 32'h0, 1'b0, n, st);
        @(negedge clk); start = 1'b1; op = DIV; a = 32'd100; b = 32'd7;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        total++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL abort: got busy=%b %h_%h want 0 0_0", busy, hi, lo); end
        repeat (12) begin
            @(negedge clk);
            if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) quiet = 1'b0;
        end
        total++; if (!quiet) begin bad++; $display("FAIL abort late update: got busy=%b %h_%h want 0 0_0", busy, hi, lo); end
        m_hi = '0; m_lo = '0;
    endtask

    task automatic test_back_to_back();
        int n; bit st;
        @(negedge clk); start = 1'b1; op = MULT; a = 32'd2; b = 32'd3;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b cycle5 busy: got %b want 1", busy); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd6) begin bad++; $display("FAIL b2b cycle6: got busy=%b %h_%h want 0 0_6", busy, hi, lo); end
        start = 1'b1; op = DIVU; a = 32'd20; b = 32'd6;
        @(negedge clk); start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b cycle7 busy: got %b want 1", busy); end
        repeat (9) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b cycle16 busy: got %b want 1", busy); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || hi !== 32'd2 || lo !== 32'd3) begin bad++; $display("FAIL b2b cycle17: got busy=%b %h_%h want 0 2_3", busy, hi, lo); end
        model(MULT, 32'd2, 32'd3);
        model(DIVU, 32'd20, 32'd6);
        run(MTHI, 32'h0, 32'h0, 1'b0, n, st);
        run(MADD, 32'd2, 32'd5, 1'b0, n, st);
`ifdef MDU_MADD_EN
        total++; if (n != 5 || hi !== 32'd0 || lo !== 32'd13) begin bad++; $display("FAIL madd: got busy=%0d %h_%h want 5 0_d", n, hi, lo); end
        run(MSUB, 32'd3, 32'd5, 1'b0, n, st);
        total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE) begin bad++; $display("FAIL msub wrap: got %h_%h want ffffffff_fffffffe", hi, lo); end
`else
        total++; if (n != 0 || hi !== 32'd0 || lo !== 32'd3) begin bad++; $display("FAIL madd noop: got busy=%0d %h_%h want 0 0_3", n, hi, lo); end
`endif
    endtask

    task automatic test_random();
        int n; bit st;
        op_t o;
        logic [31:0] x, y;
        for (int i = 0; i < 60; i++) begin
            o = op_t'($urandom_range(0, 15));
            x = $urandom; y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'h0;
                1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                2: y = $urandom_range(1, 20);
                3: y = -$urandom_range(1, 20);
                default: ;
            endcase
            run(o, x, y, i[0], n, st);
            total++; if (n != lat(o)) begin bad++; $display("FAIL rand%0d op%0d busy cycles: got %0d want %0d", i, o, n, lat(o)); end
            total++; if (!st) begin bad++; $display("FAIL rand%0d op%0d hi/lo moved while busy: got 0 want 1", i, o); end
            total++; if (hi !== m_hi || lo !== m_lo) begin bad++; $display("FAIL rand%0d op%0d a=%h b=%h: got %h_%h want %h_%h", i, o, x, y, hi, lo, m_hi, m_lo); end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu_div();
        test_mthi_div0();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit of the five-stage MIPS pipeline, fed by the execute stage. It holds the architectural HI/LO registers and executes mult/multu/div/divu as multi-cycle operations. It also handles mthi/mtlo. While an operation is in flight it raises `busy`, which the hazard unit uses to stall any later multiply/divide or HI/LO access in execute.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high. Clears all state.
- `start`  in  1: one-cycle command strobe from execute; ignored while `busy`.
- `op`  in  4: operation code, with encodings from `mdu_pkg`.
- `a`  in  32: operand rs (forwarded value).
- `b`  in  32: operand rt (forwarded value).
- `busy`  out  1: operation in flight.
- `hi`  out  32: current HI register.
- `lo`  out  32: current LO register. The mfhi/mflo path reads `hi`/`lo` combinationally.

## Operation
- Reset values:
  - `busy`=0, `hi`=0, `lo`=0.
  - Internal counter = 0, latched op = MULT, latched operands = 0.
- Idle with `start`=1, at the rising edge:
  - MULT / MULTU / DIV / DIVU: latch `op`, `a`, `b`. Load the counter with `MULT_CYCLES` or `DIV_CYCLES`. `busy`=1 from the next cycle.
  - MTHI: `hi`<=`a`.
  - MTLO: `lo`<=`a`.
  - `busy` stays 0 for both; takes effect the next cycle.
  - Undefined op code: no effect.
- Busy: the counter decrements each cycle. On the edge where it reaches 0, `hi`/`lo` are written and `busy` falls.
- Arithmetic, always on the latched operands:
  - MULT: signed 32x32→64, {hi,lo}.
  - MULTU: unsigned 32x32→64, {hi,lo}.
  - DIV: signed. lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - Divisor 0: hi/lo unchanged; the full latency is still spent.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- `start` while `busy`: ignored completely. No relatch; the current operation is unaffected.
- `reset` during an operation: the operation is aborted and `hi`/`lo` are cleared at that edge.
- The hazard unit must stall mult/div/mfhi/mflo/mthi/mtlo in execute when `busy | start`. The MDU does not check this itself.

## Timing
- `start` is sampled in cycle 0.
- `busy`=1 in cycles 1..N, where N is the latency parameter.
- Result is visible on `hi`/`lo` in cycle N+1, with `busy`=0.
- A new `start` is accepted in cycle N+1, so operations can run back to back with no gap.
- MTHI/MTLO: `start` in cycle 0, new value visible in cycle 1.
- `hi`/`lo` do not change during cycles 1..N; they keep their old values.
- No combinational path from `a`/`b`/`op`/`start` to any output.

## Configuration
- `MDU_MADD_EN`
  - Defined: adds MADD and MSUB, with MULT latency. {hi,lo} <= {hi,lo} ± signed(a)*signed(b). Accumulation uses the HI/LO values at completion and wraps modulo 2^64.
  - Undefined: these codes count as undefined and are a no-op.

## Structure
- `mdu_pkg` holds:
  - Op-code localparams: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MADD=6, MSUB=7.
  - Default latency constants.
- The decoder in the controller imports `mdu_pkg` as well.
- Single module; no sub-module. Results are computed behaviourally from the latched operands.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=5 → after 5 busy cycles: hi=0xFFFFFFFF, lo=0xFFFFFFF1. `busy` is high for exactly 5 cycles.
- MULTU a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE. Then DIV a=0xFFFFFFF9 (-7), b=2 → after 10 cycles: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MTHI a=0x12345678 then DIVU a=7, b=0 → hi=0x12345678, lo=0 unchanged after 10 busy cycles.
- MULT 3×4, then pulse `start` with DIVU 9/2 in cycle 2 → DIVU ignored. In cycle 6: lo=12, hi=0, `busy`=0.
- DIV 100/7 started, `reset` asserted in cycle 4 → from the next cycle `busy`=0, hi=lo=0. No later update occurs.
- Back-to-back: MULT 2×3 and DIVU 20/6 started in cycle 6 → lo=3, hi=2 in cycle 17. With `MDU_MADD_EN`: MADD 2×5 from hi=0, lo=3 → lo=13.
